uart_serial_tx: RTL and testbench
=================================

UART_SERIAL_TX -- requirements
Module: uart_serial_tx

Interface
REQ-001 Parameter CLK_FREQ, default 1_152_000: clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8: byte buffer depth, power of two, 2..64.
REQ-004 Port clk  input  1: single clock; all logic on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset (asserted when 0).
REQ-006 Port tx_data  input  8: byte from the uart tx_data/tx_valid byte stream.
REQ-007 Port tx_valid  input  1: one-cycle strobe; tx_data is valid this cycle. There is no ready and no backpressure.
REQ-008 Port overflow_clr  input  1: clears the sticky overflow flag.
REQ-009 Port txd  output  1: serial line, 8N1, idle high.
REQ-010 Port busy  output  1: high while a frame is on the line or the FIFO is non-empty.
REQ-011 Port overflow  output  1: sticky, set when a byte is dropped.
REQ-012 Port fifo_level  output  $clog2(FIFO_DEPTH+1): count of buffered bytes.

Function
REQ-013 DIV = CLK_FREQ/BAUD_RATE (integer division) SHALL be computed at elaboration; DIV < 2 SHALL cause an elaboration error.
REQ-014 tx_valid high with FIFO not full SHALL push tx_data; fifo_level increments on the next edge.
REQ-015 tx_valid high with FIFO full and no pop in the same cycle SHALL drop the byte and set overflow on the next edge.
REQ-016 Push and pop in the same cycle when full SHALL accept the push; fifo_level stays unchanged.
REQ-017 Overflow set and overflow_clr in the same cycle: set SHALL win.
REQ-018 FSM states: IDLE, START, DATA, STOP. Each state except IDLE lasts exactly DIV cycles per bit, counted by a baud counter that runs 0..DIV-1.
REQ-019 IDLE with FIFO non-empty: pop the head byte into the shift register, enter START, and drive txd=0.
REQ-020 START to DATA after DIV cycles. DATA shifts out 8 bits LSB first, DIV cycles each, tracked by a 3-bit bit index.
REQ-021 DATA to STOP after bit 7 completes; txd=1 for DIV cycles.
REQ-022 At the end of STOP: if FIFO non-empty, pop and go directly to START (no extra idle bit); else go to IDLE.
REQ-023 Latency: byte pushed at edge N into an empty FIFO with the FSM in IDLE → txd low after edge N+1.
REQ-024 Frame length SHALL be exactly 10*DIV cycles; back-to-back frames SHALL be gapless.
REQ-025 txd SHALL be driven directly from a flop (glitch-free).
REQ-026 busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-027 Reset asserted SHALL immediately force: txd=1, busy=0, overflow=0, fifo_level=0, state IDLE, and clear all counters and pointers.
REQ-028 Reset mid-frame SHALL abort the frame; buffered bytes are discarded and no partial frame resumes after release.
REQ-029 The first push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum (tx_state_t) and the frame constants: data bits = 8, stop bits = 1, idle level = 1.
REQ-031 Buffering SHALL be implemented in sub-module uart_byte_fifo (synchronous, width 8, depth FIFO_DEPTH, with level output). The serializer FSM lives in uart_serial_tx.

Verification (CLK_FREQ=1_152_000, BAUD_RATE=115200, DIV=10)
REQ-032 Single byte: push 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. busy falls 100 cycles after txd first goes low.
REQ-033 Back-to-back: push 0x00 then 0xFF on consecutive cycles → 200 contiguous cycles, txd never high between the first stop bit and the second start bit except during the stop bit itself.
REQ-034 Overflow: push 10 bytes on consecutive cycles with FIFO_DEPTH=8 → first byte popped, 8 buffered, 1 dropped. overflow=1, fifo_level=8, 9 frames emitted. overflow_clr → overflow=0.
REQ-035 Full plus pop: FIFO full with a push coinciding with the STOP→START pop → push accepted, overflow stays 0.
REQ-036 Reset mid-DATA: assert reset at bit 3 of 0x3C → txd=1 immediately; after release, txd stays 1 and busy=0.
REQ-037 Simultaneous set and clear: overflow_clr and a dropped push in the same cycle → overflow=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_serial_tx_if.sv
// Byte stream into the transmitter: tx_valid is a one-cycle strobe qualifying
// tx_data; there is no ready, so the consumer must take or drop every byte.
interface uart_serial_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (output tx_data, output tx_valid);
  modport slave  (input  tx_data, input  tx_valid);

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with occupancy output; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; level and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_serial_tx.sv
// 8N1 UART transmitter: buffers strobed bytes and serializes them LSB first,
// back-to-back frames without idle gaps.
import uart_pkg::*;

module uart_serial_tx #(
  parameter int CLK_FREQ   = 1_152_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  uart_serial_tx_if.slave                   bus,
  input  logic                              overflow_clr,
  output logic                              txd,
  output logic                              busy,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output tx_state_t                         state_dbg
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("uart_serial_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_serial_tx: FIFO_DEPTH must be a power of two in 2..64");
  end
  if (STOP_BITS != 1 || DATA_BITS != 8) begin : g_frame_check
    $error("uart_serial_tx: serializer supports 8 data bits and 1 stop bit only");
  end

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]       fifo_data;
  logic             baud_end;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.tx_valid),
    .push_data (bus.tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_end = (baud_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          baud_d   = '0;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            txd_d   = IDLE_LEVEL;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames stay gapless.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            txd_d    = 1'b0;
            state_d  = START;
          end else begin
            txd_d   = IDLE_LEVEL;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        txd_d   = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // A byte is lost only when full and the serializer is not draining this cycle.
  assign drop = bus.tx_valid && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || (fifo_level != '0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_serial_tx.sv
// Self-checking bench for uart_serial_tx: directed scenarios plus random
// traffic, compared every cycle against a frame-timing reference model.
module tb_uart_serial_tx;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1_152_000;
  localparam int BAUD_RATE  = 115200;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;
  localparam int FRAME      = 10 * DIV;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_LIMIT = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             overflow_clr;
  logic             txd;
  logic             busy;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;
  tx_state_t        state_dbg;

  uart_serial_tx_if bus ();

  uart_serial_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .overflow_clr (overflow_clr),
    .txd          (txd),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifo_level),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, the frame on the line and its elapsed time.
  logic [7:0] exp_q[$];
  bit         m_active;
  logic [7:0] m_byte;
  int         m_t;
  bit         m_ovf;
  int         n_checks;
  int         n_fail;

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit clr);
    bit pop, accept, drop;
    pop    = (exp_q.size() > 0) && (!m_active || m_t == FRAME - 1);
    accept = v && (exp_q.size() < FIFO_DEPTH || pop);
    drop   = v && !accept;
    if (pop) begin
      m_byte   = exp_q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end else if (m_active) begin
      if (m_t == FRAME - 1) m_active = 1'b0;
      else                  m_t++;
    end
    if (accept) exp_q.push_back(d);
    if (drop)      m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".txd"},      32'(txd),        32'(exp_txd()));
    check({tag, ".busy"},     32'(busy),       32'(m_active || exp_q.size() != 0));
    check({tag, ".level"},    32'(fifo_level), 32'(exp_q.size()));
    check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr, input string tag);
    bus.tx_valid = v;
    bus.tx_data  = d;
    overflow_clr = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 8'($urandom), 1'b0, tag);
  endtask

  // Advance until the model's frame clock reads target_t after an edge.
  task automatic wait_frame_t(input int target_t, input string tag);
    int guard = 0;
    while (!(m_active && m_t == target_t) && guard < WAIT_LIMIT) begin
      step(1'b0, 8'($urandom), 1'b0, tag);
      guard++;
    end
    check({tag, ".wait"}, 32'(guard < WAIT_LIMIT), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".txd"},      32'(txd),        32'd1);
    check({tag, ".busy"},     32'(busy),       32'd0);
    check({tag, ".level"},    32'(fifo_level), 32'd0);
    check({tag, ".overflow"}, 32'(overflow),   32'd0);
    check({tag, ".state"},    32'(state_dbg),  32'(IDLE));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    overflow_clr = 1'b0;
    model_reset();

    // Reset takes effect without a clock edge.
    #2 reset = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset_hold");
    @(negedge clk) reset = 1'b1;

    // Single byte on the first edge after release.
    step(1'b1, 8'hA5, 1'b0, "single_push");
    check("single_first_level", 32'(fifo_level), 32'd1);
    step(1'b0, 8'h00, 1'b0, "single_start");
    check("single_start_low", 32'(txd), 32'd0);
    idle(FRAME + 10, "single");
    check("single_done_busy", 32'(busy), 32'd0);

    // Back-to-back frames.
    step(1'b1, 8'h00, 1'b0, "b2b");
    step(1'b1, 8'hFF, 1'b0, "b2b");
    idle(2 * FRAME + 10, "b2b");

    // Ten consecutive pushes: one popped, eight buffered, one dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, "ovf_fill");
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_level", 32'(fifo_level), 32'd8);
    step(1'b0, 8'h00, 1'b1, "ovf_clr");
    check("ovf_cleared", 32'(overflow), 32'd0);
    idle(9 * FRAME + 20, "ovf_drain");

    // Full FIFO, push lands on the STOP->START pop edge.
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, "full_fill");
    wait_frame_t(FRAME - 1, "full_wait");
    step(1'b1, 8'($urandom), 1'b0, "full_pop");
    check("full_pop_overflow", 32'(overflow),   32'd0);
    check("full_pop_level",    32'(fifo_level), 32'd8);

    // Dropped push with a simultaneous clear: set wins.
    step(1'b1, 8'($urandom), 1'b1, "set_clr");
    check("set_clr_overflow", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, "set_clr_release");
    idle(9 * FRAME + 20, "full_drain");

    // Random traffic with occasional bursts and clears.
    for (int i = 0; i < 1500; i++) begin
      bit v;
      v = ($urandom_range(0, 99) < 3) || ((i % 300) < 6);
      step(v, 8'($urandom), ($urandom_range(0, 49) == 0), "random");
    end
    idle(9 * FRAME + 20, "random_drain");

    // Reset in the middle of data bit 3 of 0x3C.
    step(1'b1, 8'h3C, 1'b0, "midreset_push");
    wait_frame_t(4 * DIV + 3, "midreset_wait");
    check("midreset_bit3", 32'(txd), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_state("midreset");
    model_reset();
    @(posedge clk);
    #1 check_reset_state("midreset_hold");
    @(negedge clk) reset = 1'b1;
    idle(2 * FRAME, "after_reset");
    check("after_reset_txd",  32'(txd),  32'd1);
    check("after_reset_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
